// File: rtl/cpu_pkg.sv
// Shared types and default constants for the unified memory port arbiter.
package cpu_pkg;

   typedef enum logic {
      IDLE,
      WAIT
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_I,
      OWN_D
   } arb_owner_t;

   localparam int unsigned MEM_LAT_DEF    = 1;
   localparam int unsigned STREAK_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and load/store requests onto one single-ported memory.
// Data wins by default; a streak counter forces a fetch through after STREAK_MAX
// consecutive data grants made while a fetch was waiting.
module mem_port_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned STREAK_MAX = STREAK_MAX_DEF,
   parameter int unsigned AW         = 32,
   parameter int unsigned DW         = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_gnt,
   output logic            i_rvalid,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW/8-1:0] d_we,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_gnt,
   output logic            d_rvalid,
   output logic [DW-1:0]   d_rdata,
   output logic            m_en,
   output logic [AW-1:0]   m_addr,
   output logic [DW/8-1:0] m_dwe,
   output logic [DW-1:0]   m_wdata,
   input  logic [DW-1:0]   m_rdata
);

   localparam int unsigned LW = $clog2(MEM_LAT + 1);
   localparam int unsigned SW = $clog2(STREAK_MAX + 1);

   arb_state_t      r_state,   w_state_nxt;
   arb_owner_t      r_owner,   w_owner_nxt;
   logic [LW-1:0]   r_lat_cnt, w_lat_cnt_nxt;
   logic [SW-1:0]   r_streak,  w_streak_nxt;
   logic            r_d_store, w_d_store_nxt;

   logic            w_resp;
   logic            w_grant_ok;
   logic            w_gnt_i;
   logic            w_gnt_d;

   // Response cycle doubles as the earliest slot for the next command.
   assign w_resp     = (r_state == WAIT) && (r_lat_cnt == LW'(1));
   assign w_grant_ok = (r_state == IDLE) || w_resp;
   assign w_gnt_d    = w_grant_ok && d_req && !(i_req && (r_streak == SW'(STREAK_MAX)));
   assign w_gnt_i    = w_grant_ok && !w_gnt_d && i_req;

   // State registers with synchronous reset; an in-flight transaction is simply dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_owner   <= OWN_NONE;
         r_lat_cnt <= '0;
         r_streak  <= '0;
         r_d_store <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_owner   <= w_owner_nxt;
         r_lat_cnt <= w_lat_cnt_nxt;
         r_streak  <= w_streak_nxt;
         r_d_store <= w_d_store_nxt;
      end
   end

   // Next-state: FSM, latency down-counter, store flag and streak counter.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_lat_cnt_nxt = r_lat_cnt;
      w_streak_nxt  = r_streak;
      w_d_store_nxt = r_d_store;

      if (w_gnt_d || w_gnt_i) begin
         w_state_nxt   = WAIT;
         w_owner_nxt   = w_gnt_d ? OWN_D : OWN_I;
         w_lat_cnt_nxt = LW'(MEM_LAT);
         w_d_store_nxt = w_gnt_d && (d_we != '0);
      end else if (r_state == WAIT) begin
         w_lat_cnt_nxt = r_lat_cnt - LW'(1);
         if (w_resp) begin
            w_state_nxt = IDLE;
            w_owner_nxt = OWN_NONE;
         end
      end

      if (w_gnt_i) begin
         w_streak_nxt = '0;
      end else if (w_gnt_d) begin
         if (!i_req) begin
            w_streak_nxt = '0;
         end else if (r_streak != SW'(STREAK_MAX)) begin
            w_streak_nxt = r_streak + SW'(1);
         end
      end
   end

   // Outputs: grant mux onto the memory port and response steering; all quiet in reset.
   always_comb begin
      i_gnt    = 1'b0;
      d_gnt    = 1'b0;
      m_en     = 1'b0;
      m_addr   = '0;
      m_dwe    = '0;
      m_wdata  = '0;
      i_rvalid = 1'b0;
      i_rdata  = '0;
      d_rvalid = 1'b0;
      d_rdata  = '0;
      if (!reset) begin
         i_gnt = w_gnt_i;
         d_gnt = w_gnt_d;
         m_en  = w_gnt_i || w_gnt_d;
         if (w_gnt_d) begin
            m_addr  = d_addr;
            m_dwe   = d_we;
            m_wdata = d_wdata;
         end else if (w_gnt_i) begin
            m_addr = i_addr;
         end
         if (w_resp && (r_owner == OWN_I)) begin
            i_rvalid = 1'b1;
            i_rdata  = m_rdata;
         end
         if (w_resp && (r_owner == OWN_D)) begin
            d_rvalid = 1'b1;
            if (!r_d_store) begin
               d_rdata = m_rdata;
            end
         end
      end
   end

endmodule
